// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalisation remap builder.
package hist_eq_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_LOG_NUM_PIXELS = 18;

    // Bit offset of map entry k inside the flat o_map_domain vector.
    function automatic int unsigned map_offset(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/hist_cdf_scaler.sv
// One CDF step: saturating running-sum update, then scale-and-clamp of the new sum
// into a DataWidth map entry.
module hist_cdf_scaler
    import hist_eq_pkg::*;
#(
    parameter int unsigned DataWidth    = DEF_DATA_WIDTH,
    parameter int unsigned numIntLevels = 2 ** DataWidth,
    parameter int unsigned LogNumPixels = DEF_LOG_NUM_PIXELS,
    parameter int unsigned CountWidth   = LogNumPixels + 1
) (
    input  logic [CountWidth-1:0] i_sum,
    input  logic [CountWidth-1:0] i_bin,
    output logic [CountWidth-1:0] o_sum_c,
    output logic [DataWidth-1:0]  o_entry_c
);

    localparam int unsigned ProdWidth = CountWidth + DataWidth;

    logic [CountWidth:0]   sum_ext;
    logic [CountWidth-1:0] sum_sat;
    logic [ProdWidth-1:0]  prod;
    logic [ProdWidth-1:0]  scaled;

    always_comb begin
        o_sum_c   = '0;
        o_entry_c = '0;
        sum_ext   = {1'b0, i_sum} + {1'b0, i_bin};
        sum_sat   = sum_ext[CountWidth] ? {CountWidth{1'b1}} : sum_ext[CountWidth-1:0];
        prod      = ProdWidth'(sum_sat) * ProdWidth'(numIntLevels - 1);
        scaled    = prod >> LogNumPixels;
        // Frames larger than nominal would overshoot the top level without this clamp.
        if (scaled > ProdWidth'(numIntLevels - 1)) begin
            o_entry_c = DataWidth'(numIntLevels - 1);
        end else begin
            o_entry_c = scaled[DataWidth-1:0];
        end
        o_sum_c = sum_sat;
    end

endmodule

// File: rtl/hist_map_builder.sv
// Per-frame histogram -> CDF -> intensity remap table builder.
// HIST_MAP_SHADOW_EN: when defined the table is built in a shadow and published atomically.
module hist_map_builder
    import hist_eq_pkg::*;
#(
    parameter int unsigned DataWidth    = DEF_DATA_WIDTH,
    parameter int unsigned numIntLevels = 2 ** DataWidth,
    parameter int unsigned LogNumPixels = DEF_LOG_NUM_PIXELS,
    parameter int unsigned CountWidth   = LogNumPixels + 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_enable,
    input  logic [DataWidth-1:0]              i_pixel_value,
    input  logic                              i_pixel_valid,
    input  logic                              i_pixel_last,
    output logic                              o_pixel_ready,
    output logic [DataWidth*numIntLevels-1:0] o_map_domain,
    output logic                              o_map_valid,
    output logic                              o_busy
);

    localparam int unsigned MapWidth = DataWidth * numIntLevels;
    localparam int unsigned IdxWidth = DataWidth + 1;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   scan_idx_q, scan_idx_d;
    logic [CountWidth-1:0] sum_q, sum_d;
    logic [CountWidth-1:0] bin_q [numIntLevels];
    logic [CountWidth-1:0] bin_d [numIntLevels];
    logic [MapWidth-1:0]   map_q, map_d;
    logic                  map_valid_q, map_valid_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  wr_en_q, wr_en_d;
    logic [DataWidth-1:0]  wr_idx_q, wr_idx_d;
    logic [DataWidth-1:0]  wr_val_q, wr_val_d;
`ifdef HIST_MAP_SHADOW_EN
    logic [DataWidth-1:0]  shadow_q [numIntLevels];
    logic [DataWidth-1:0]  shadow_d [numIntLevels];
`endif

    logic                  accept_c;
    logic                  scan_act_c;
    logic [CountWidth-1:0] scan_sum_c;
    logic [DataWidth-1:0]  scan_entry_c;

    hist_cdf_scaler #(
        .DataWidth    (DataWidth),
        .numIntLevels (numIntLevels),
        .LogNumPixels (LogNumPixels),
        .CountWidth   (CountWidth)
    ) u_scaler (
        .i_sum     (sum_q),
        .i_bin     (bin_q[scan_idx_q[DataWidth-1:0]]),
        .o_sum_c   (scan_sum_c),
        .o_entry_c (scan_entry_c)
    );

    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        sum_d       = sum_q;
        map_d       = map_q;
        map_valid_d = 1'b0;
        ready_d     = ready_q;
        busy_d      = busy_q;
        wr_en_d     = 1'b0;
        wr_idx_d    = wr_idx_q;
        wr_val_d    = wr_val_q;
`ifdef HIST_MAP_SHADOW_EN
        shadow_d    = shadow_q;
`endif
        accept_c    = i_enable & i_pixel_valid & ready_q & (state_q == ACCUM);
        scan_act_c  = (state_q == SCAN) & ~scan_idx_q[DataWidth];

        // Bins are plain registers, so repeated values on consecutive cycles just count.
        for (int unsigned i = 0; i < numIntLevels; i++) begin
            bin_d[i] = bin_q[i];
            if (accept_c && (i_pixel_value == DataWidth'(i)) && (bin_q[i] != {CountWidth{1'b1}})) begin
                bin_d[i] = bin_q[i] + CountWidth'(1);
            end
            if (scan_act_c && (scan_idx_q[DataWidth-1:0] == DataWidth'(i))) begin
                bin_d[i] = '0;
            end
        end

        // Scaled entries land one cycle after their scan step to keep the multiply off the write path.
        if (wr_en_q) begin
`ifdef HIST_MAP_SHADOW_EN
            shadow_d[wr_idx_q] = wr_val_q;
`else
            map_d[map_offset(32'(wr_idx_q), DataWidth) +: DataWidth] = wr_val_q;
`endif
        end

        case (state_q)
            ACCUM: begin
                if (accept_c && i_pixel_last) begin
                    state_d    = SCAN;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                    scan_idx_d = '0;
                    sum_d      = '0;
                end
            end
            SCAN: begin
                if (scan_act_c) begin
                    sum_d      = scan_sum_c;
                    wr_en_d    = 1'b1;
                    wr_idx_d   = scan_idx_q[DataWidth-1:0];
                    wr_val_d   = scan_entry_c;
                    scan_idx_d = scan_idx_q + IdxWidth'(1);
                end else begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
`ifdef HIST_MAP_SHADOW_EN
                for (int unsigned k = 0; k < numIntLevels; k++) begin
                    map_d[map_offset(k, DataWidth) +: DataWidth] = shadow_q[k];
                end
`endif
                map_valid_d = 1'b1;
                ready_d     = 1'b1;
                busy_d      = 1'b0;
                sum_d       = '0;
                scan_idx_d  = '0;
                state_d     = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ACCUM;
            scan_idx_q  <= '0;
            sum_q       <= '0;
            map_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_idx_q    <= '0;
            wr_val_q    <= '0;
            for (int unsigned i = 0; i < numIntLevels; i++) begin
                bin_q[i] <= '0;
            end
            // Identity table lets the mapper pass pixels through before the first frame.
            for (int unsigned k = 0; k < numIntLevels; k++) begin
                map_q[map_offset(k, DataWidth) +: DataWidth] <= DataWidth'(k);
            end
        end else begin
            state_q     <= state_d;
            scan_idx_q  <= scan_idx_d;
            sum_q       <= sum_d;
            map_valid_q <= map_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            wr_idx_q    <= wr_idx_d;
            wr_val_q    <= wr_val_d;
            bin_q       <= bin_d;
            map_q       <= map_d;
        end
    end

`ifdef HIST_MAP_SHADOW_EN
    always_ff @(posedge i_clk) begin
        shadow_q <= shadow_d;
    end
`endif

    assign o_pixel_ready = ready_q;
    assign o_map_domain  = map_q;
    assign o_map_valid   = map_valid_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_hist_map_builder.sv
// Directed bench for hist_map_builder (DataWidth=3, LogNumPixels=4) with a frame-level reference model.
module tb_hist_map_builder;

    localparam int DW   = 3;
    localparam int LNP  = 4;
    localparam int NL   = 8;
    localparam int CW   = 5;
    localparam int MAXC = 31;
    localparam int LAT  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [DW-1:0]     pval = '0;
    logic              pv = 1'b0;
    logic              pl = 1'b0;
    logic              ready;
    logic [DW*NL-1:0]  map_dom;
    logic              map_valid;
    logic              busy;

    always #5 clk = ~clk;

    hist_map_builder #(
        .DataWidth    (DW),
        .numIntLevels (NL),
        .LogNumPixels (LNP),
        .CountWidth   (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .i_pixel_value (pval),
        .i_pixel_valid (pv),
        .i_pixel_last  (pl),
        .o_pixel_ready (ready),
        .o_map_domain  (map_dom),
        .o_map_valid   (map_valid),
        .o_busy        (busy)
    );

    // Reference model: histogram, pending table and a countdown to publication.
    int hist [NL];
    int map_m [NL];
    int pend [NL];
    bit ready_m = 1'b1;
    bit valid_m = 1'b0;
    bit busy_m  = 1'b0;
    int cnt_m   = 0;
    bit chk_en  = 1'b0;
    int n_cmp   = 0;
    int n_fail  = 0;

    function automatic logic [DW*NL-1:0] pack_map(input int m [NL]);
        logic [DW*NL-1:0] r;
        r = '0;
        for (int k = 0; k < NL; k++) r[k*DW +: DW] = DW'(m[k]);
        return r;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string nm, input logic [DW*NL-1:0] act, input logic [DW*NL-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_lit(input string nm, input int e [NL]);
        check_vec(nm, map_dom, pack_map(e));
    endtask

    task automatic model_edge(input bit r, input bit e, input bit v, input bit l, input int val);
        int s;
        if (!r) begin
            for (int k = 0; k < NL; k++) begin
                hist[k]  = 0;
                map_m[k] = k;
            end
            ready_m = 1'b1;
            valid_m = 1'b0;
            busy_m  = 1'b0;
            cnt_m   = 0;
        end else begin
            valid_m = 1'b0;
            if (cnt_m > 0) begin
                cnt_m--;
                if (cnt_m == 0) begin
                    map_m   = pend;
                    valid_m = 1'b1;
                    ready_m = 1'b1;
                    busy_m  = 1'b0;
                end
            end else if (e && v && ready_m) begin
                if (hist[val] < MAXC) hist[val]++;
                if (l) begin
                    s = 0;
                    for (int k = 0; k < NL; k++) begin
                        s = s + hist[k];
                        if (s > MAXC) s = MAXC;
                        pend[k] = (s * (NL - 1)) >> LNP;
                        if (pend[k] > NL - 1) pend[k] = NL - 1;
                        hist[k] = 0;
                    end
                    cnt_m   = LAT;
                    ready_m = 1'b0;
                    busy_m  = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit v, input bit l, input int val);
        @(negedge clk);
        rst_n = r;
        en    = e;
        pv    = v;
        pl    = l;
        pval  = DW'(val);
        @(posedge clk);
        model_edge(r, e, v, l, val);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", int'(ready), int'(ready_m));
            check("map_valid", int'(map_valid), int'(valid_m));
            check("busy", int'(busy), int'(busy_m));
`ifndef HIST_MAP_SHADOW_EN
            if (!busy_m)
`endif
            check_vec("map_domain", map_dom, pack_map(map_m));
        end
    end

    // Samples from the last-pixel edge onward; optionally offers pixels while the block is scanning.
    task automatic wait_map(input bit drive_v);
        int lo;
        int vat;
        int vcnt;
        lo   = 0;
        vat  = -1;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) cyc(1'b1, 1'b1, drive_v && (i < LAT), 1'b0, 0);
            #1;
            if (!ready) lo++;
            if (map_valid) begin
                vcnt++;
                vat = i;
            end
        end
        check("ready_low_cycles", lo, LAT);
        check("valid_pulses", vcnt, 1);
        check("valid_latency", vat, LAT);
    endtask

    task automatic run_frame(input int q [$], input bit drive_v);
        for (int i = 0; i < q.size(); i++) cyc(1'b1, 1'b1, 1'b1, i == q.size() - 1, q[i]);
        wait_map(drive_v);
    endtask

    initial begin
        int q [$];
        int lit [NL];
        int vcnt;

        for (int k = 0; k < NL; k++) map_m[k] = k;

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk_en = 1'b1;
        #1;
        lit = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_lit("reset_identity", lit);
        check("reset_ready", int'(ready), 1);
        check("reset_valid", int'(map_valid), 0);

        q = {};
        for (int i = 0; i < 16; i++) q.push_back(0);
        run_frame(q, 1'b0);
        lit = '{7, 7, 7, 7, 7, 7, 7, 7};
        check_lit("all_zero_frame", lit);

        q = {};
        for (int v = 0; v < NL; v++) begin
            q.push_back(v);
            q.push_back(v);
        end
        run_frame(q, 1'b0);
        lit = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_lit("uniform_frame", lit);

        q = {};
        for (int i = 0; i < 16; i++) q.push_back(0);
        run_frame(q, 1'b0);
        lit = '{7, 7, 7, 7, 7, 7, 7, 7};
        check_lit("bins_cleared", lit);

        q = {};
        for (int i = 0; i < 40; i++) q.push_back(5);
        run_frame(q, 1'b0);
        lit = '{0, 0, 0, 0, 0, 7, 7, 7};
        check_lit("overflow_clamp", lit);

        cyc(1'b1, 1'b0, 1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 0);
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(3);
        run_frame(q, 1'b1);
        lit = '{0, 0, 0, 3'd7, 7, 7, 7, 7};
        check_lit("ignored_pixels", lit);

        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b1, i == 15, 2);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        #1;
        lit = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_lit("midscan_reset_identity", lit);
        check("midscan_reset_ready", int'(ready), 1);
        check("midscan_reset_busy", int'(busy), 0);
        vcnt = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
            #1;
            if (map_valid) vcnt++;
        end
        check("midscan_no_pulse", vcnt, 0);

        q = {};
        for (int v = 0; v < NL; v++) begin
            q.push_back(v);
            q.push_back(v);
        end
        run_frame(q, 1'b0);
        lit = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_lit("after_reset_frame", lit);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
